// File: rtl/snake_engine.sv
// snake_engine: parametrised grid snake core. Keeps the body as a shift
// buffer of (x,y) cells, tracks length/food/score, detects wall and self
// collisions, and answers registered head/body/food queries for the
// pixel colour stage.
module snake_engine #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int XW       = 6,
    parameter int YW       = 5,
    parameter int MAX_LEN  = 32,
    parameter int LW       = 6,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 0
) (
    input  logic          CLK_100MHz,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Tick,
    input  logic [1:0]    Dir,
    input  logic [XW-1:0] RandX,
    input  logic [YW-1:0] RandY,
    input  logic [XW-1:0] QueryX,
    input  logic [YW-1:0] QueryY,
    output logic          HeadHit,
    output logic          BodyHit,
    output logic          FoodHit,
    output logic [XW-1:0] HeadX,
    output logic [YW-1:0] HeadY,
    output logic [LW-1:0] Length,
    output logic [LW-1:0] Score,
    output logic          Running,
    output logic          GameOver
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_t;

    localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
    localparam logic [YW-1:0] Y_START   = YW'(GRID_H / 2);
    localparam logic [XW-1:0] X_FOOD    = XW'(GRID_W * 3 / 4);
    localparam logic [LW-1:0] L_INIT    = LW'(INIT_LEN);
    localparam logic [LW-1:0] L_MAX     = LW'(MAX_LEN);
    localparam logic [LW-1:0] SCORE_SAT = '1;

    state_t                       state_q, state_d;
    logic [MAX_LEN-1:0][XW-1:0]   seg_x_q, seg_x_d;
    logic [MAX_LEN-1:0][YW-1:0]   seg_y_q, seg_y_d;
    logic [LW-1:0]                len_q, len_d, score_q, score_d;
    logic [XW-1:0]                food_x_q, food_x_d;
    logic [YW-1:0]                food_y_q, food_y_d;
    logic [1:0]                   dir_q, dir_d;
    logic                         head_hit_q, body_hit_q, food_hit_q;

    logic [1:0]    dir_eff;
    logic [XW-1:0] nx, rx_c;
    logic [YW-1:0] ny, ry_c;
    logic          wall, eat, self_hit, body_match;

    // Step datapath: effective direction, next head cell, wall/eat/self checks
    always_comb begin
        dir_eff = (Dir == (dir_q ^ 2'd2)) ? dir_q : Dir;
        nx      = seg_x_q[0];
        ny      = seg_y_q[0];
        wall    = 1'b0;
        case (dir_eff)
            2'd0: if (seg_y_q[0] == '0) begin
                      if (WRAP != 0) ny = Y_MAX; else wall = 1'b1;
                  end else ny = seg_y_q[0] - YW'(1);
            2'd1: if (seg_x_q[0] == X_MAX) begin
                      if (WRAP != 0) nx = '0; else wall = 1'b1;
                  end else nx = seg_x_q[0] + XW'(1);
            2'd2: if (seg_y_q[0] == Y_MAX) begin
                      if (WRAP != 0) ny = '0; else wall = 1'b1;
                  end else ny = seg_y_q[0] + YW'(1);
            default: if (seg_x_q[0] == '0) begin
                      if (WRAP != 0) nx = X_MAX; else wall = 1'b1;
                  end else nx = seg_x_q[0] - XW'(1);
        endcase
        eat = (nx == food_x_q) && (ny == food_y_q);
        // The tail cell vacates on a plain move, so it only blocks when eating
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (seg_x_q[i] == nx && seg_y_q[i] == ny &&
                ((i + 1 < int'(len_q)) || (eat && (i + 1 == int'(len_q)))))
                self_hit = 1'b1;
        end
        rx_c = (int'(RandX) >= GRID_W) ? RandX - XW'(GRID_W) : RandX;
        ry_c = (int'(RandY) >= GRID_H) ? RandY - YW'(GRID_H) : RandY;
    end

    // Game FSM and next-state for the segment buffer, length, score, food
    always_comb begin
        state_d  = state_q;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        len_d    = len_q;
        score_d  = score_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        dir_d    = dir_q;
        case (state_q)
            S_RUN: if (Tick) begin
                dir_d = dir_eff;
                if (wall || self_hit) begin
                    state_d = S_OVER;
                end else begin
                    seg_x_d = {seg_x_q[MAX_LEN-2:0], nx};
                    seg_y_d = {seg_y_q[MAX_LEN-2:0], ny};
                    if (eat) begin
                        if (len_q != L_MAX)       len_d   = len_q + LW'(1);
                        if (score_q != SCORE_SAT) score_d = score_q + LW'(1);
                        food_x_d = rx_c;
                        food_y_d = ry_c;
                    end
                end
            end
            default: if (Go) begin
                state_d = S_RUN;
                for (int i = 0; i < MAX_LEN; i++) begin
                    seg_x_d[i] = (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
                    seg_y_d[i] = (i < INIT_LEN) ? Y_START : '0;
                end
                len_d    = L_INIT;
                score_d  = '0;
                dir_d    = 2'd1;
                food_x_d = X_FOOD;
                food_y_d = Y_START;
            end
        endcase
    end

    // Game state registers
    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            seg_x_q  <= '0;
            seg_y_q  <= '0;
            len_q    <= '0;
            score_q  <= '0;
            food_x_q <= '0;
            food_y_q <= '0;
            dir_q    <= '0;
        end else begin
            state_q  <= state_d;
            seg_x_q  <= seg_x_d;
            seg_y_q  <= seg_y_d;
            len_q    <= len_d;
            score_q  <= score_d;
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
            dir_q    <= dir_d;
        end
    end

    // Body match over live non-head segments only
    always_comb begin
        body_match = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (i < int'(len_q) && seg_x_q[i] == QueryX && seg_y_q[i] == QueryY)
                body_match = 1'b1;
        end
    end

    // Registered query answers; silent in IDLE, last frame held in OVER
    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            head_hit_q <= 1'b0;
            body_hit_q <= 1'b0;
            food_hit_q <= 1'b0;
        end else begin
            head_hit_q <= (state_q != S_IDLE) && seg_x_q[0] == QueryX && seg_y_q[0] == QueryY;
            body_hit_q <= (state_q != S_IDLE) && body_match;
            food_hit_q <= (state_q != S_IDLE) && food_x_q == QueryX && food_y_q == QueryY;
        end
    end

    assign HeadHit  = head_hit_q;
    assign BodyHit  = body_hit_q;
    assign FoodHit  = food_hit_q;
    assign HeadX    = seg_x_q[0];
    assign HeadY    = seg_y_q[0];
    assign Length   = len_q;
    assign Score    = score_q;
    assign Running  = (state_q == S_RUN);
    assign GameOver = (state_q == S_OVER);

endmodule
